// File: rtl/product_acc_pkg.sv
// Shared types and defaults for the product accumulator.
// Default widths and the burst length limit are used by product_acc and its adder.
package product_acc_pkg;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_e;

    localparam int unsigned PROD_W_D = 8;
    localparam int unsigned ACC_W_D  = 16;
    localparam int unsigned CNT_W_D  = 4;

    // Longest burst the term counter can describe.
    function automatic int unsigned max_terms(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/product_acc_add.sv
// Accumulator adder: acc + zero-extended product with carry out.
// Saturates to all-ones on carry when PRODUCT_ACC_SAT_EN is defined, otherwise wraps.
module product_acc_add #(
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] addend_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    logic [ACC_W:0] full;

    assign full    = {1'b0, acc_i} + {1'b0, addend_i};
    assign carry_o = full[ACC_W];

`ifdef PRODUCT_ACC_SAT_EN
    assign sum_o = full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum_o = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_acc.sv
// Burst accumulator for the multiplier product stream; one result per burst.
// Build option PRODUCT_ACC_SAT_EN selects saturating accumulation (see product_acc_add).
module product_acc
    import product_acc_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_D,
    parameter int unsigned ACC_W  = ACC_W_D,
    parameter int unsigned CNT_W  = CNT_W_D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prod_valid_i,
    output logic              prod_ready_o,
    input  logic [PROD_W-1:0] prod_data_i,
    input  logic              prod_last_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [ACC_W-1:0]  res_data_o,
    output logic [CNT_W-1:0]  res_count_o,
    output logic              res_ovf_o
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(max_terms(CNT_W));

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ovf_q, ovf_d, carry;
    logic             ready_q;
    logic             accept;
    logic             res_hs;

    assign accept  = prod_valid_i && ready_q;
    assign res_hs  = (state_q == S_OUT) && res_ready_i;
    assign cnt_inc = cnt_q + 1'b1;

    product_acc_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .acc_i   (acc_q),
        .addend_i(ACC_W'(prod_data_i)),
        .sum_o   (sum),
        .carry_o (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_ACC: if (accept && (prod_last_i || cnt_inc == MaxCnt)) state_d = S_OUT;
            S_OUT: if (res_ready_i) state_d = S_ACC;
            default: state_d = S_ACC;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            acc_d = sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | carry;
        end else if (res_hs) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Ready is registered from the next state so it stays low through reset and
    // carries no combinational path from res_ready_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ready_q <= (state_d == S_ACC);
        end
    end

    always_comb begin
        prod_ready_o = ready_q;
        res_valid_o  = (state_q == S_OUT);
        res_data_o   = res_valid_o ? acc_q : '0;
        res_count_o  = res_valid_o ? cnt_q : '0;
        res_ovf_o    = res_valid_o && ovf_q;
    end

endmodule

// File: tb/tb_product_acc.sv
// Self-checking bench: default-width DUT and a 10-bit accumulator DUT share one
// stimulus stream; a scoreboard holds expected burst results.
module tb_product_acc;

    logic       clk;
    logic       rst_n;
    logic       prod_valid;
    logic [7:0] prod_data;
    logic       prod_last;
    logic       res_ready;

    logic        rdy_a, rv_a, ro_a;
    logic [15:0] rd_a;
    logic [3:0]  rc_a;
    logic        rdy_b, rv_b, ro_b;
    logic [9:0]  rd_b;
    logic [3:0]  rc_b;

    typedef struct {
        logic [15:0] da;
        logic        da_o;
        logic [9:0]  db;
        logic        db_o;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   m_sum;
    int   m_cnt;
    int   passed;
    int   total;

    product_acc u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .prod_valid_i(prod_valid),
        .prod_ready_o(rdy_a),
        .prod_data_i (prod_data),
        .prod_last_i (prod_last),
        .res_valid_o (rv_a),
        .res_ready_i (res_ready),
        .res_data_o  (rd_a),
        .res_count_o (rc_a),
        .res_ovf_o   (ro_a)
    );

    product_acc #(
        .PROD_W(8),
        .ACC_W (10),
        .CNT_W (4)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .prod_valid_i(prod_valid),
        .prod_ready_o(rdy_b),
        .prod_data_i (prod_data),
        .prod_last_i (prod_last),
        .res_valid_o (rv_b),
        .res_ready_i (res_ready),
        .res_data_o  (rd_b),
        .res_count_o (rc_b),
        .res_ovf_o   (ro_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_accept(input logic [7:0] d, input logic last);
        exp_t e;
        m_sum += int'(d);
        m_cnt++;
        if (last || m_cnt == 15) begin
            e.da   = 16'(m_sum % 65536);
            e.da_o = (m_sum >= 65536);
`ifdef PRODUCT_ACC_SAT_EN
            e.db   = (m_sum > 1023) ? 10'd1023 : 10'(m_sum);
`else
            e.db   = 10'(m_sum % 1024);
`endif
            e.db_o = (m_sum >= 1024);
            e.cnt  = 4'(m_cnt);
            sb.push_back(e);
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic put(input logic [7:0] d, input logic last);
        int n = 0;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = last;
        while (!rdy_a && n < 50) begin
            tick();
            n++;
        end
        chk("put_accept", 32'(rdy_a), 1);
        if (rdy_a) model_accept(d, last);
        tick();
    endtask

    task automatic idle();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        prod_data  = 8'd0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && rv_a && res_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(rv_a), 0);
            end else begin
                e = sb.pop_front();
                chk("res_data_a", 32'(rd_a), 32'(e.da));
                chk("res_count_a", 32'(rc_a), 32'(e.cnt));
                chk("res_ovf_a", 32'(ro_a), 32'(e.da_o));
                chk("res_valid_b", 32'(rv_b), 1);
                chk("res_data_b", 32'(rd_b), 32'(e.db));
                chk("res_count_b", 32'(rc_b), 32'(e.cnt));
                chk("res_ovf_b", 32'(ro_b), 32'(e.db_o));
            end
        end
    end

    initial begin
        int n;
        passed = 0;
        total  = 0;
        m_sum  = 0;
        m_cnt  = 0;
        rst_n  = 1'b0;
        res_ready = 1'b1;
        idle();

        // Reset state
        tick();
        chk("rst_ready", 32'(rdy_a), 0);
        chk("rst_valid", 32'(rv_a), 0);
        chk("rst_data", 32'(rd_a), 0);
        chk("rst_count", 32'(rc_a), 0);
        chk("rst_ovf", 32'(ro_a), 0);
        rst_n = 1'b1;
        #1;
        chk("release_ready_low", 32'(rdy_a), 0);
        tick();
        chk("release_ready_high", 32'(rdy_a), 1);

        // Reset mid-burst discards partial sum
        put(8'd200, 1'b0);
        put(8'd100, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(rdy_a), 0);
        chk("midrst_valid", 32'(rv_a), 0);
        chk("midrst_data", 32'(rd_a), 0);
        chk("midrst_count", 32'(rc_a), 0);
        m_sum = 0;
        m_cnt = 0;
        tick();
        rst_n = 1'b1;
        tick();
        put(8'd7, 1'b1);
        idle();
        chk("single_valid", 32'(rv_a), 1);
        chk("single_data", 32'(rd_a), 7);
        tick();
        chk("single_ready_back", 32'(rdy_a), 1);
        chk("single_valid_drop", 32'(rv_a), 0);

        // Basic burst
        put(8'd225, 1'b0);
        chk("basic_no_early_valid", 32'(rv_a), 0);
        put(8'd225, 1'b1);
        idle();
        chk("basic_valid", 32'(rv_a), 1);
        chk("basic_data", 32'(rd_a), 32'h01C2);
        chk("basic_count", 32'(rc_a), 2);
        tick();

        // Forced end at 15 terms; 16th term stalls then starts the next burst
        for (int i = 0; i < 15; i++) put(8'd10, 1'b0);
        chk("forced_stall_ready", 32'(rdy_a), 0);
        chk("forced_valid", 32'(rv_a), 1);
        chk("forced_data", 32'(rd_a), 150);
        chk("forced_count", 32'(rc_a), 15);
        put(8'd10, 1'b0);
        put(8'd5, 1'b1);
        idle();
        chk("forced_next_data", 32'(rd_a), 15);
        tick();

        // Backpressure
        res_ready = 1'b0;
        put(8'd3, 1'b0);
        put(8'd4, 1'b1);
        idle();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rv_a), 1);
            chk("bp_data", 32'(rd_a), 7);
            chk("bp_count", 32'(rc_a), 2);
            chk("bp_ovf", 32'(ro_a), 0);
            chk("bp_ready", 32'(rdy_a), 0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        chk("bp_ready_back", 32'(rdy_a), 1);
        chk("bp_valid_drop", 32'(rv_a), 0);

        // Overflow in the 10-bit instance
        for (int i = 0; i < 4; i++) put(8'd225, 1'b0);
        put(8'd225, 1'b1);
        idle();
        chk("ovf_a_data", 32'(rd_a), 1125);
        chk("ovf_a_flag", 32'(ro_a), 0);
`ifdef PRODUCT_ACC_SAT_EN
        chk("ovf_b_data", 32'(rd_b), 1023);
`else
        chk("ovf_b_data", 32'(rd_b), 101);
`endif
        chk("ovf_b_flag", 32'(ro_b), 1);
        tick();

        // Stall/idle mixing with stray last pulses
        for (int i = 1; i <= 6; i++) begin
            n = int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++) begin
                prod_valid = 1'b0;
                prod_last  = 1'b1;
                prod_data  = 8'd99;
                tick();
            end
            put(8'(i), (i == 6));
        end
        idle();
        chk("mix_data", 32'(rd_a), 21);
        chk("mix_count", 32'(rc_a), 6);
        tick();

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("sb_drain", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/product_acc.md
Name: product_acc

Overview:
- Sequential accumulator directly downstream of the 4x4 array multiplier.
- Consumes the 8-bit product stream (valid/ready), sums a burst of products into a wider register, and presents one result per burst.
- Burst ends on a tagged last term or when the term counter fills.
- Result is held until the consumer accepts it. This forms the multiply-accumulate datapath of the design.

Parameters:
- PROD_W, 8, product input width.
- ACC_W, 16, accumulator/result width; must be >= PROD_W.
- CNT_W, 4, term counter width; maximum burst length is 2^CNT_W-1 (15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- prod_valid  in  1  product present.
- prod_ready  out  1  block accepts product this cycle.
- prod_data  in  PROD_W  unsigned product.
- prod_last  in  1  qualifies prod_data as the final term of the burst.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts result.
- res_data  out  ACC_W  burst sum.
- res_count  out  CNT_W  number of terms summed.
- res_ovf  out  1  sticky: a carry out of ACC_W occurred during the burst.

Behaviour:
- Reset (async, rst_n=0):
  - state=S_ACC; acc=0, cnt=0, ovf=0.
  - prod_ready=0 while rst_n=0, then 1 from the first clock after release.
  - res_valid=0, res_data=0, res_count=0, res_ovf=0.
- FSM states: S_ACC, S_OUT. All outputs are registered or decoded from state; no combinational path from res_ready to prod_ready.
- S_ACC:
  - prod_ready=1, res_valid=0.
  - A term is accepted when prod_valid && prod_ready. On accept:
    - acc <= acc + zero-extended prod_data, modulo 2^ACC_W.
    - ovf |= carry out of the add.
    - cnt <= cnt+1.
  - Go to S_OUT if the accepted term has prod_last=1, or if cnt+1 == 2^CNT_W-1 (forced end at 15 terms).
  - prod_last with prod_valid=0 is ignored.
- S_OUT:
  - prod_ready=0; res_valid=1.
  - res_data=acc, res_count=cnt, res_ovf=ovf, all stable until the handshake.
  - On res_valid && res_ready: acc, cnt, ovf <= 0 and state goes to S_ACC.
  - res_ready while res_valid=0 has no effect.
- Latency and throughput:
  - res_valid rises the cycle after the last term is accepted.
  - The cycle after the result handshake prod_ready is 1 again. This gives one bubble per burst.
  - A burst of N terms with no stalls occupies N+1 cycles minimum.
- Zero-valued products count as terms: cnt increments, acc is unchanged.
- A burst can never be empty; the result always reports at least 1 term.
- Reset mid-burst or mid-S_OUT discards all state with no result emitted.
- prod_data, prod_last and prod_valid are sampled only when accepted. Values presented while prod_ready=0 are ignored, and the upstream must hold them.

Optional Feature:
- Macro PRODUCT_ACC_SAT_EN.
- Defined: an addition that would carry out of ACC_W clamps acc to all-ones (2^ACC_W-1) and sets ovf. Subsequent terms leave acc at all-ones.
- Undefined: wrap modulo 2^ACC_W with ovf sticky as above.
- Port list is identical in both builds.

Decomposition:
- Package product_acc_pkg holds:
  - state enum type {S_ACC, S_OUT}.
  - default width constants PROD_W_D=8, ACC_W_D=16, CNT_W_D=4.
  - function max_terms(CNT_W) = 2^CNT_W-1.
- One natural sub-module: product_acc_add. It is a combinational ACC_W adder taking acc and the zero-extended product and returning sum and carry. It contains the PRODUCT_ACC_SAT_EN clamp, which isolates the only build-dependent logic.
- FSM, counter and registers stay in product_acc.

Test Plan:
- Reset check: assert rst_n=0 mid-burst after terms 200 and 100 → all outputs 0 immediately. After release, single term 7 with last → res_data=7, res_count=1, res_ovf=0.
- Basic burst: terms 225, 225 (last) → res_valid the cycle after the 2nd accept, res_data=0x01C2 (450), res_count=2, res_ovf=0.
- Forced end: 16 consecutive terms of 10, never last → result after the 15th with res_data=150 and res_count=15. The 16th term is stalled (prod_ready=0), then becomes term 1 of the next burst.
- Backpressure: hold res_ready=0 for 5 cycles in S_OUT → res_data, res_count, res_ovf stable, prod_ready=0 throughout. Raise res_ready → prod_ready=1 on the next cycle.
- Overflow (ACC_W=10): five terms of 225 (last on 5th), where the true sum is 1125.
  - Without the macro: res_data=101, res_ovf=1.
  - With PRODUCT_ACC_SAT_EN: res_data=1023, res_ovf=1.
- Stall/idle mixing: prod_valid toggling randomly with terms 1..6 (last on 6) and prod_last pulsed while prod_valid=0 → res_data=21, res_count=6.
